// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin packet arbiter sharing one UART transmitter between NUM_REQ
//   byte-stream requesters. A grant is held until the granted requester's
//   last byte has completed on the line, so packets never interleave. Only
//   one byte is outstanding in the transmitter at any time.
//
// Optional build macro: UART_ARB_TIMEOUT_EN
//   When defined, a stalled mid-packet grant (granted requester not valid)
//   is revoked after TIMEOUT cycles and timeout_o pulses for one cycle.
//   When undefined, timeout_o is tied low and grants are held indefinitely.
//
// Ports:
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   enable_i              allows new grants (never aborts a packet)
//   req_valid_i[N]        per-requester byte valid
//   req_data_i[8N]        per-requester byte, requester k at [8k+7:8k]
//   req_last_i[N]         byte is last of its packet
//   req_ready_o[N]        byte accepted this cycle (one-hot or zero)
//   grant_o[N]            registered one-hot grant, or zero
//   busy_o                arbiter not idle
//   tx_en_o/tx_valid_o/tx_data_o   transmitter drive
//   tx_consume_i          transmitter accepted the byte (pulse)
//   tx_done_i             transmitter finished the stop bit (pulse)
//   timeout_o             one-cycle pulse when a grant is revoked
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 enable_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 tx_en_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_consume_i,
    input  logic                 tx_done_i,
    output logic                 timeout_o
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [IW-1:0]        r_ptr, w_ptr_nxt;
    logic [IW-1:0]        r_gidx, w_gidx_nxt;
    logic                 r_last, w_last_nxt;
    logic [IW-1:0]        w_win_idx;
    logic                 w_win_found;
    logic                 w_g_valid;
    logic                 w_accept;
    logic [7:0]           w_g_data;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]          r_stall, w_stall_nxt;
    logic                 r_timeout, w_timeout_nxt;
`endif

    // Round-robin search starting just after the last-served requester.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned idx;
            idx = (32'(r_ptr) + i) % NUM_REQ;
            if (!w_win_found && req_valid_i[IW'(idx)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        w_g_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (r_gidx == IW'(k)) begin
                w_g_data = req_data_i[8*k +: 8];
            end
        end
    end

    assign w_g_valid = req_valid_i[r_gidx];
    assign w_accept  = tx_consume_i & w_g_valid;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ptr     <= IW'(NUM_REQ - 1);
            r_gidx    <= '0;
            r_last    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_stall   <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gidx    <= w_gidx_nxt;
            r_last    <= w_last_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_stall   <= w_stall_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        tx_en_o     = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
`ifdef UART_ARB_TIMEOUT_EN
        // Held at zero outside GRANT, which clears it on every GRANT entry.
        w_stall_nxt   = (r_state == GRANT) ? r_stall : '0;
        w_timeout_nxt = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (enable_i && w_win_found) begin
                    w_state_nxt = GRANT;
                    w_gidx_nxt  = w_win_idx;
                    w_grant_nxt = NUM_REQ'(1) << w_win_idx;
                end
            end

            GRANT: begin
                tx_en_o     = 1'b1;
                tx_valid_o  = w_g_valid;
                tx_data_o   = w_g_data;
                // r_grant is one-hot on the granted requester.
                req_ready_o = w_accept ? r_grant : '0;
                if (w_accept) begin
                    w_last_nxt  = req_last_i[r_gidx];
                    w_state_nxt = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    w_stall_nxt = '0;
`endif
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!w_g_valid) begin
                    if (r_stall == 16'(TIMEOUT - 1)) begin
                        w_state_nxt   = IDLE;
                        w_ptr_nxt     = r_gidx;
                        w_grant_nxt   = '0;
                        w_stall_nxt   = '0;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_stall_nxt = r_stall + 16'd1;
                    end
                end
`endif
            end

            WAIT_DONE: begin
                if (tx_done_i) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = r_gidx;
                        w_grant_nxt = '0;
                    end else begin
                        w_state_nxt = GRANT;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant_o = r_grant;
    assign busy_o  = (r_state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              enable_i;
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;
    logic              tx_en_o;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_consume_i;
    logic              tx_done_i;
    logic              timeout_o;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard entries: {expected grant one-hot, expected byte}
    logic [11:0] sb [$];

    // Per-requester byte FIFOs: {last, data}
    logic [8:0]  rmem  [NREQ][8];
    int unsigned rhead [NREQ] = '{0, 0, 0, 0};
    int unsigned rtail [NREQ] = '{0, 0, 0, 0};

    uart_tx_arbiter #(
        .NUM_REQ(NREQ),
        .TIMEOUT(10)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .enable_i     (enable_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .tx_en_o      (tx_en_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_consume_i (tx_consume_i),
        .tx_done_i    (tx_done_i),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_valid_i[k] = (rhead[k] != rtail[k]);
            {req_last_i[k], req_data_i[8*k +: 8]} = rmem[k][rhead[k] % 8];
        end
    end

    always @(posedge clk_i) begin
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready_o[k]) rhead[k] <= rhead[k] + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input int k, input logic [7:0] data, input logic last);
        rmem[k][rtail[k] % 8] = {last, data};
        rtail[k] = rtail[k] + 1;
    endtask

    // Acts as the transmitter for one byte: wait for valid, check against
    // scoreboard, pulse consume, optionally pulse done after a short gap.
    task automatic do_byte(input bit with_done);
        logic [11:0] exp;
        int c;
        c = 0;
        while (tx_valid_o !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        chk("tx_valid_wait", {31'd0, tx_valid_o}, 32'd1);
        n_vec++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_empty: observed byte %0h expected none", tx_data_o);
        end
        exp = (sb.size() != 0) ? sb.pop_front() : 12'h000;
        chk("tx_en", {31'd0, tx_en_o}, 32'd1);
        chk("tx_data", {24'd0, tx_data_o}, {24'd0, exp[7:0]});
        chk("grant", {28'd0, grant_o}, {28'd0, exp[11:8]});
        tx_consume_i = 1'b1;
        #1;
        chk("ready", {28'd0, req_ready_o}, {28'd0, exp[11:8]});
        tick();
        tx_consume_i = 1'b0;
        #1;
        chk("wait_tx_en", {31'd0, tx_en_o}, 32'd0);
        if (with_done) begin
            tick();
            tx_done_i = 1'b1;
            tick();
            tx_done_i = 1'b0;
        end
    endtask

    initial begin
        rstn_i       = 1'b0;
        enable_i     = 1'b1;
        tx_consume_i = 1'b0;
        tx_done_i    = 1'b0;
        #1;
        // Reset state
        chk("rst_grant", {28'd0, grant_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_tx_en", {31'd0, tx_en_o}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();

        // req0 three-byte packet
        push_req(0, 8'h41, 1'b0); sb.push_back({4'b0001, 8'h41});
        push_req(0, 8'h42, 1'b0); sb.push_back({4'b0001, 8'h42});
        push_req(0, 8'h43, 1'b1); sb.push_back({4'b0001, 8'h43});
        chk("grant_before_edge", {28'd0, grant_o}, 32'd0);
        tick();
        chk("grant_req0", {28'd0, grant_o}, 32'b0001);
        do_byte(1'b1);
        do_byte(1'b1);
        do_byte(1'b1);
        chk("t1_busy_after_last", {31'd0, busy_o}, 32'd0);
        chk("t1_grant_after_last", {28'd0, grant_o}, 32'd0);

        // req1 and req3 simultaneously, pointer at 0
        push_req(1, 8'h11, 1'b1); sb.push_back({4'b0010, 8'h11});
        push_req(3, 8'h33, 1'b1); sb.push_back({4'b1000, 8'h33});
        do_byte(1'b1);
        chk("t2_idle_between", {31'd0, busy_o}, 32'd0);
        do_byte(1'b1);

        // req2 two-byte packet, req0 arrives mid-packet
        push_req(2, 8'hAA, 1'b0); sb.push_back({4'b0100, 8'hAA});
        push_req(2, 8'h55, 1'b1); sb.push_back({4'b0100, 8'h55});
        do_byte(1'b0);
        push_req(0, 8'h01, 1'b1); sb.push_back({4'b0001, 8'h01});
        tick();
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        chk("t3_grant_held", {28'd0, grant_o}, 32'b0100);
        do_byte(1'b1);
        do_byte(1'b1);

        // enable gating
        enable_i = 1'b0;
        push_req(0, 8'h5A, 1'b1); sb.push_back({4'b0001, 8'h5A});
        tick(); tick(); tick();
        chk("t4_grant_disabled", {28'd0, grant_o}, 32'd0);
        chk("t4_tx_en_disabled", {31'd0, tx_en_o}, 32'd0);
        chk("t4_busy_disabled", {31'd0, busy_o}, 32'd0);
        enable_i = 1'b1;
        tick();
        chk("t4_grant_enabled", {28'd0, grant_o}, 32'b0001);
        do_byte(1'b1);

        // reset while in WAIT_DONE
        push_req(2, 8'h77, 1'b0); sb.push_back({4'b0100, 8'h77});
        push_req(2, 8'h78, 1'b0);
        do_byte(1'b0);
        rstn_i = 1'b0;
        #1;
        chk("t5_rst_grant", {28'd0, grant_o}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        push_req(2, 8'h79, 1'b1);
        push_req(0, 8'h90, 1'b1);
        sb.push_back({4'b0001, 8'h90});
        sb.push_back({4'b0100, 8'h78});
        sb.push_back({4'b0100, 8'h79});
        tick(); tick();
        rstn_i = 1'b1;
        do_byte(1'b1);
        do_byte(1'b1);
        do_byte(1'b1);

        // stall mid-packet
        push_req(1, 8'hC1, 1'b0); sb.push_back({4'b0010, 8'hC1});
        do_byte(1'b1);
        push_req(2, 8'hD2, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 9; i++) tick();
        chk("t6_no_timeout_yet", {31'd0, timeout_o}, 32'd0);
        chk("t6_grant_stalled", {28'd0, grant_o}, 32'b0010);
        tick();
        chk("t6_timeout_pulse", {31'd0, timeout_o}, 32'd1);
        chk("t6_grant_revoked", {28'd0, grant_o}, 32'd0);
        tick();
        chk("t6_timeout_cleared", {31'd0, timeout_o}, 32'd0);
        sb.push_back({4'b0100, 8'hD2});
        do_byte(1'b1);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("t6_grant_held", {28'd0, grant_o}, 32'b0010);
        chk("t6_busy_held", {31'd0, busy_o}, 32'd1);
        chk("t6_no_timeout", {31'd0, timeout_o}, 32'd0);
        chk("t6_tx_valid_low", {31'd0, tx_valid_o}, 32'd0);
        push_req(1, 8'hC2, 1'b1);
        sb.push_back({4'b0010, 8'hC2});
        sb.push_back({4'b0100, 8'hD2});
        do_byte(1'b1);
        do_byte(1'b1);
`endif
        chk("end_busy", {31'd0, busy_o}, 32'd0);
        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drained: observed %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin packet arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters. It grants one requester at a time and holds the grant until that requester's last byte has finished on the line, so packets never interleave. It drives the transmitter's enable/valid/data inputs and consumes its consume and done (hazir) pulses. Only one byte is outstanding in the transmitter at any time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 1000, stall cycles before a mid-packet grant is revoked (used only with UART_ARB_TIMEOUT_EN; 16-bit)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
enable_i  in  1  1 = new grants allowed; does not abort a packet in progress
req_valid_i  in  NUM_REQ  per-requester byte valid
req_data_i  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
req_last_i  in  NUM_REQ  byte is last of packet; qualified by valid
req_ready_o  out  NUM_REQ  byte accepted this cycle (one-hot or zero)
grant_o  out  NUM_REQ  registered one-hot grant, or zero
busy_o  out  1  state != IDLE
tx_en_o  out  1  transmitter enable
tx_valid_o  out  1  byte valid to transmitter
tx_data_o  out  8  byte to transmitter
tx_consume_i  in  1  transmitter accepted the byte (1-cycle pulse)
tx_done_i  in  1  transmitter finished the stop bit (1-cycle pulse)
timeout_o  out  1  1-cycle pulse when a grant is revoked

Behaviour:
- Reset values: state IDLE; grant_o=0; last-grant pointer = NUM_REQ-1, so requester 0 has first priority; all outputs 0.
- States: IDLE, GRANT, WAIT_DONE.
- IDLE -> GRANT: when enable_i=1 and any req_valid_i bit is set.
  - Winner = first valid requester searching from pointer+1, wrapping modulo NUM_REQ.
  - Winner is registered into grant_o, so the grant is visible 1 cycle after the request.
- In GRANT, with g the granted requester:
  - tx_en_o=1; tx_valid_o=req_valid_i[g]; tx_data_o=req_data_i[g].
  - req_ready_o[g]=tx_consume_i & req_valid_i[g]; all other ready bits are 0.
  - On consume: latch req_last_i[g] into last_r and go to WAIT_DONE.
- In every state other than GRANT: tx_en_o=0, tx_valid_o=0, tx_data_o=0.
- WAIT_DONE, on tx_done_i:
  - If last_r=1: go to IDLE, pointer<=g, grant_o<=0.
  - Otherwise: go back to GRANT.
- Re-arbitration after a packet ends takes at least one IDLE cycle. enable_i=0 holds the block in IDLE.
- A tx_done_i pulse in IDLE or GRANT, or a tx_consume_i pulse outside GRANT, is ignored.
- Consume and done for the same byte cannot coincide. If they occur in the same cycle, consume wins only in GRANT and done wins only in WAIT_DONE.
- A requester dropping valid mid-packet stalls in GRANT. Without the optional feature, the grant is held indefinitely.
- Only one grant is ever active. A single requester that is continuously valid gets back-to-back packets, each separated by one IDLE cycle.
- Reset asserted mid-operation returns the block to IDLE immediately. The transmitter is reset by its own logic.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter clears on entering GRANT and on each consume.
  - It increments each GRANT cycle with req_valid_i[g]=0.
  - When it reaches TIMEOUT: timeout_o pulses for 1 cycle, state goes to IDLE, pointer<=g, grant_o<=0.
  - The counter does not run in WAIT_DONE.
- Not defined: no counter, timeout_o tied 0, grant held until last byte.

Test Plan:
- Reset, then req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43); done after each consume -> three consumes, grant_o=0001 throughout, busy_o falls the cycle after the 3rd done, pointer=0.
- req1 and req3 valid simultaneously, pointer=0, 1-byte packets each -> req1 granted first (grant_o=0010), then req3 (1000); at most one ready bit high per cycle.
- req2 holds packet 0xAA,0x55 while req0 becomes valid mid-packet -> req0 waits until req2's last done; no interleaving on tx_data_o.
- enable_i=0 with req0 valid -> grant_o stays 0, tx_en_o=0; enable_i=1 -> grant_o=0001 the next cycle.
- rstn_i asserted in WAIT_DONE -> grant_o=0, busy_o=0, tx_valid_o=0 immediately; after release, arbitration restarts at req0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=10: req1 sends a non-last byte then drops valid -> timeout_o pulses 10 cycles after re-entering GRANT, grant released; pending req2 is granted next.
